// File: rtl/branch_recovery_ctrl_pkg.sv
// Shared definitions for the branch recovery controller.
package branch_recovery_ctrl_pkg;

  // Conditional branch opcode (RISC-V B-type)
  localparam logic [6:0] B_TYPE = 7'b1100011;

  // Next-PC source select encodings
  localparam logic [1:0] PC_SEL_SEQ      = 2'b00;
  localparam logic [1:0] PC_SEL_PRED     = 2'b01;
  localparam logic [1:0] PC_SEL_FIX_TGT  = 2'b10;
  localparam logic [1:0] PC_SEL_FIX_SEQ  = 2'b11;

  // Controller state
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

endpackage

// File: rtl/branch_recovery_ctrl_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Increment on inc unless already saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Branch resolution and misprediction recovery controller.
// Detects mispredicted branches at EX/MEM, redirects fetch, and holds
// the front end flushed for a fixed number of unstalled cycles.
module branch_recovery_ctrl
  import branch_recovery_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [6:0]            ex_mem_opcode,
  input  logic                  ex_mem_branch_taken,
  input  logic                  ex_mem_prediction,
  input  logic [DATA_WIDTH-1:0] ex_mem_branch_target,
  input  logic [DATA_WIDTH-1:0] ex_mem_pc,
  input  logic                  if_prediction,
  input  logic                  i_stall,
  output logic [1:0]            o_pc_sel,
  output logic [DATA_WIDTH-1:0] o_pc_redirect,
  output logic                  o_flush,
  output logic                  o_bp_update_en,
  output logic [CNT_WIDTH-1:0]  o_branch_cnt,
  output logic [CNT_WIDTH-1:0]  o_mispredict_cnt,
  output logic                  o_busy
);

  // Last window count value before returning to RUN (window is 1..7 cycles)
  localparam logic [2:0]            WIN_LAST = 3'(FLUSH_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);

  state_t     state;
  logic [2:0] win_cnt;
  logic       resolve;
  logic       mispredict;

  // A branch resolves only in RUN with the pipeline moving; in RECOVER
  // anything at EX/MEM is wrong-path and must be ignored.
  assign resolve    = (ex_mem_opcode == B_TYPE) && !i_stall && (state == ST_RUN);
  assign mispredict = resolve && (ex_mem_branch_taken != ex_mem_prediction);

  // Redirect, flush and predictor update are combinational so the
  // correction reaches fetch in the same cycle the branch resolves.
  always_comb begin
    o_pc_sel       = PC_SEL_SEQ;
    o_pc_redirect  = '0;
    o_flush        = 1'b0;
    o_bp_update_en = 1'b0;
    if (state == ST_RECOVER) begin
      o_flush = 1'b1;
    end else begin
      o_bp_update_en = resolve;
      if (mispredict) begin
        o_flush = 1'b1;
        if (ex_mem_branch_taken) begin
          o_pc_sel      = PC_SEL_FIX_TGT;
          o_pc_redirect = ex_mem_branch_target;
        end else begin
          o_pc_sel      = PC_SEL_FIX_SEQ;
          o_pc_redirect = ex_mem_pc + PC_STEP;
        end
      end else if (if_prediction) begin
        o_pc_sel = PC_SEL_PRED;
      end
    end
  end

  assign o_busy = (state == ST_RECOVER);

  // FSM: enter RECOVER on mispredict, leave after FLUSH_CYCLES unstalled cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_RUN;
      win_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          win_cnt <= '0;
          if (mispredict) begin
            state <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (!i_stall) begin
            if (win_cnt == WIN_LAST) begin
              state   <= ST_RUN;
              win_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + 3'd1;
            end
          end
        end
        default: begin
          state   <= ST_RUN;
          win_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (resolve),
    .count (o_branch_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (mispredict),
    .count (o_mispredict_cnt)
  );

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed testbench for branch_recovery_ctrl (FLUSH_CYCLES=2, CNT_WIDTH=4).
module tb_branch_recovery_ctrl;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] ALU = 7'b0110011;

  logic          clk;
  logic          rst_n;
  logic [6:0]    opcode;
  logic          taken;
  logic          pred;
  logic [DW-1:0] target;
  logic [DW-1:0] pc;
  logic          if_pred;
  logic          stall;
  logic [1:0]    pc_sel;
  logic [DW-1:0] redirect;
  logic          flush;
  logic          upd;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] mp_cnt;
  logic          busy;

  int errors = 0;
  int checks = 0;

  branch_recovery_ctrl #(
    .DATA_WIDTH  (DW),
    .FLUSH_CYCLES(2),
    .CNT_WIDTH   (CW)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .ex_mem_opcode       (opcode),
    .ex_mem_branch_taken (taken),
    .ex_mem_prediction   (pred),
    .ex_mem_branch_target(target),
    .ex_mem_pc           (pc),
    .if_prediction       (if_pred),
    .i_stall             (stall),
    .o_pc_sel            (pc_sel),
    .o_pc_redirect       (redirect),
    .o_flush             (flush),
    .o_bp_update_en      (upd),
    .o_branch_cnt        (br_cnt),
    .o_mispredict_cnt    (mp_cnt),
    .o_busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [6:0] op, input logic tk, input logic pr,
                       input logic [DW-1:0] tg, input logic [DW-1:0] p,
                       input logic ifp, input logic st);
    opcode = op; taken = tk; pred = pr; target = tg; pc = p;
    if_pred = ifp; stall = st;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive(ALU, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(ALU, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    checks++; if (br_cnt !== 4'h0) begin errors++; $display("FAIL reset_br_cnt: got %0h expected 0", br_cnt); end
    checks++; if (mp_cnt !== 4'h0) begin errors++; $display("FAIL reset_mp_cnt: got %0h expected 0", mp_cnt); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0h expected 0", flush); end
    checks++; if (pc_sel !== 2'b00) begin errors++; $display("FAIL reset_pc_sel: got %0h expected 0", pc_sel); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_prediction_select();
    apply_reset();
    @(negedge clk);
    drive(ALU, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0); #1;
    checks++; if (pc_sel !== 2'b01) begin errors++; $display("FAIL pred_sel_1: got %0h expected 1", pc_sel); end
    checks++; if (redirect !== 32'h0) begin errors++; $display("FAIL pred_redirect: got %0h expected 0", redirect); end
    @(negedge clk);
    drive(ALU, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0); #1;
    checks++; if (pc_sel !== 2'b00) begin errors++; $display("FAIL pred_sel_0: got %0h expected 0", pc_sel); end
  endtask

  task automatic test_correct_taken();
    apply_reset();
    @(negedge clk);
    drive(BR, 1'b1, 1'b1, 32'h80, 32'h20, 1'b0, 1'b0); #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL ct_flush: got %0h expected 0", flush); end
    checks++; if (upd !== 1'b1) begin errors++; $display("FAIL ct_upd: got %0h expected 1", upd); end
    @(negedge clk);
    drive(ALU, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0); #1;
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL ct_upd_after: got %0h expected 0", upd); end
    checks++; if (br_cnt !== 4'h1) begin errors++; $display("FAIL ct_br_cnt: got %0h expected 1", br_cnt); end
    checks++; if (mp_cnt !== 4'h0) begin errors++; $display("FAIL ct_mp_cnt: got %0h expected 0", mp_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ct_busy: got %0h expected 0", busy); end
  endtask

  task automatic test_mispredict_not_taken();
    int nflush = 0;
    int nbusy  = 0;
    apply_reset();
    @(negedge clk);
    drive(BR, 1'b0, 1'b1, 32'h40, 32'h100, 1'b0, 1'b0); #1;
    checks++; if (pc_sel !== 2'b11) begin errors++; $display("FAIL mnt_pc_sel: got %0h expected 3", pc_sel); end
    checks++; if (redirect !== 32'h104) begin errors++; $display("FAIL mnt_redirect: got %0h expected 104", redirect); end
    nflush += int'(flush); nbusy += int'(busy);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(ALU, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0); #1;
      nflush += int'(flush); nbusy += int'(busy);
    end
    checks++; if (nflush != 3) begin errors++; $display("FAIL mnt_flush_cycles: got %0d expected 3", nflush); end
    checks++; if (nbusy != 2) begin errors++; $display("FAIL mnt_busy_cycles: got %0d expected 2", nbusy); end
    checks++; if (mp_cnt !== 4'h1) begin errors++; $display("FAIL mnt_mp_cnt: got %0h expected 1", mp_cnt); end
  endtask

  task automatic test_mispredict_taken_wrong_path();
    int nredir = 0;
    apply_reset();
    @(negedge clk);
    drive(BR, 1'b1, 1'b0, 32'h40, 32'h200, 1'b0, 1'b0); #1;
    checks++; if (pc_sel !== 2'b10) begin errors++; $display("FAIL mt_pc_sel: got %0h expected 2", pc_sel); end
    checks++; if (redirect !== 32'h40) begin errors++; $display("FAIL mt_redirect: got %0h expected 40", redirect); end
    if (redirect == 32'h40) nredir++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(BR, 1'b0, 1'b1, 32'h40, 32'h300, 1'b1, 1'b0); #1;
      if (redirect == 32'h40) nredir++;
      checks++; if (upd !== 1'b0) begin errors++; $display("FAIL mt_wrong_path_upd: got %0h expected 0", upd); end
      checks++; if (pc_sel !== 2'b00) begin errors++; $display("FAIL mt_wrong_path_sel: got %0h expected 0", pc_sel); end
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mt_wrong_path_flush: got %0h expected 1", flush); end
    end
    @(negedge clk);
    drive(ALU, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0); #1;
    checks++; if (nredir != 1) begin errors++; $display("FAIL mt_redirect_count: got %0d expected 1", nredir); end
    checks++; if (br_cnt !== 4'h1) begin errors++; $display("FAIL mt_br_cnt: got %0h expected 1", br_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mt_busy_end: got %0h expected 0", busy); end
  endtask

  task automatic test_stall();
    int nflush = 0;
    int nbusy  = 0;
    logic [4:0] st_pat;
    st_pat = 5'b00010;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(BR, 1'b0, 1'b1, 32'h40, 32'h100, 1'b0, 1'b1); #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL st_flush_during_stall: got %0h expected 0", flush); end
      checks++; if (upd !== 1'b0) begin errors++; $display("FAIL st_upd_during_stall: got %0h expected 0", upd); end
    end
    @(negedge clk);
    drive(BR, 1'b0, 1'b1, 32'h40, 32'h100, 1'b0, 1'b0); #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL st_flush_release: got %0h expected 1", flush); end
    checks++; if (pc_sel !== 2'b11) begin errors++; $display("FAIL st_pc_sel_release: got %0h expected 3", pc_sel); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(ALU, 1'b0, 1'b0, '0, '0, 1'b0, st_pat[i]); #1;
      nflush += int'(flush); nbusy += int'(busy);
    end
    checks++; if (nbusy != 3) begin errors++; $display("FAIL st_busy_extended: got %0d expected 3", nbusy); end
    checks++; if (nflush != 3) begin errors++; $display("FAIL st_flush_extended: got %0d expected 3", nflush); end
    checks++; if (br_cnt !== 4'h1) begin errors++; $display("FAIL st_br_cnt: got %0h expected 1", br_cnt); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (i == 14) begin
        checks++; if (br_cnt !== 4'hE) begin errors++; $display("FAIL sat_br_cnt_14: got %0h expected e", br_cnt); end
      end
      if (i == 15) begin
        checks++; if (br_cnt !== 4'hF) begin errors++; $display("FAIL sat_br_cnt_15: got %0h expected f", br_cnt); end
      end
      drive(BR, 1'b0, 1'b0, '0, 32'(i * 4), 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(ALU, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0); #1;
    checks++; if (br_cnt !== 4'hF) begin errors++; $display("FAIL sat_br_cnt_20: got %0h expected f", br_cnt); end
    checks++; if (mp_cnt !== 4'h0) begin errors++; $display("FAIL sat_mp_cnt: got %0h expected 0", mp_cnt); end
  endtask

  task automatic test_reset_mid_recover();
    apply_reset();
    @(negedge clk);
    drive(BR, 1'b1, 1'b0, 32'h40, 32'h100, 1'b0, 1'b0); #1;
    @(negedge clk);
    drive(ALU, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmr_busy_before: got %0h expected 1", busy); end
    rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmr_busy_async: got %0h expected 0", busy); end
    checks++; if (br_cnt !== 4'h0) begin errors++; $display("FAIL rmr_br_cnt_async: got %0h expected 0", br_cnt); end
    checks++; if (mp_cnt !== 4'h0) begin errors++; $display("FAIL rmr_mp_cnt_async: got %0h expected 0", mp_cnt); end
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rmr_flush_after: got %0h expected 0", flush); end
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL rmr_upd_after: got %0h expected 0", upd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmr_busy_after: got %0h expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    @(negedge clk);
    drive(BR, 1'b0, 1'b0, '0, 32'h10, 1'b0, 1'b0); #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL b2b_first_flush: got %0h expected 0", flush); end
    @(negedge clk);
    drive(BR, 1'b1, 1'b0, 32'h500, 32'h14, 1'b1, 1'b0); #1;
    checks++; if (redirect !== 32'h500) begin errors++; $display("FAIL b2b_redirect: got %0h expected 500", redirect); end
    @(negedge clk);
    drive(ALU, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0); #1;
    checks++; if (br_cnt !== 4'h2) begin errors++; $display("FAIL b2b_br_cnt: got %0h expected 2", br_cnt); end
    checks++; if (mp_cnt !== 4'h1) begin errors++; $display("FAIL b2b_mp_cnt: got %0h expected 1", mp_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(ALU, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    test_reset();
    test_prediction_select();
    test_correct_taken();
    test_mispredict_not_taken();
    test_mispredict_taken_wrong_path();
    test_stall();
    test_saturation();
    test_reset_mid_recover();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_recovery_ctrl.md
BRANCH_RECOVERY_CTRL -- requirements
Module: branch_recovery_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, PC and target width.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, recovery window length in cycles, legal range 1..7.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-004 The block SHALL have port i_clk input 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_rst_n input 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port ex_mem_opcode input 7: opcode of the instruction resolving in EX/MEM.
REQ-007 The block SHALL have port ex_mem_branch_taken input 1: actual branch outcome.
REQ-008 The block SHALL have port ex_mem_prediction input 1: prediction made for that branch (predictor checkout).
REQ-009 The block SHALL have port ex_mem_branch_target input DATA_WIDTH: computed taken target.
REQ-010 The block SHALL have port ex_mem_pc input DATA_WIDTH: PC of the resolving instruction.
REQ-011 The block SHALL have port if_prediction input 1: predictor output for the current fetch.
REQ-012 The block SHALL have port i_stall input 1: pipeline hazard stall; EX/MEM contents held while high.
REQ-013 The block SHALL have port o_pc_sel output 2: 00 sequential, 01 predicted target, 10 correction to ex_mem_branch_target, 11 correction to ex_mem_pc+4.
REQ-014 The block SHALL have port o_pc_redirect output DATA_WIDTH: correction PC, valid when o_pc_sel[1]=1, else 0.
REQ-015 The block SHALL have port o_flush output 1: flush IF/ID and ID/EX.
REQ-016 The block SHALL have port o_bp_update_en output 1: predictor write enable.
REQ-017 The block SHALL have port o_branch_cnt output CNT_WIDTH: resolved branches.
REQ-018 The block SHALL have port o_mispredict_cnt output CNT_WIDTH: mispredicted branches.
REQ-019 The block SHALL have port o_busy output 1: high while state is RECOVER.

Function
REQ-020 Resolve event SHALL be ex_mem_opcode==7'b1100011 and i_stall==0 and state==RUN.
REQ-021 Mispredict SHALL be a resolve event with ex_mem_branch_taken != ex_mem_prediction.
REQ-022 On mispredict, in the same cycle (combinational): o_flush=1; o_pc_sel=10 if taken, else 11; o_pc_redirect=target or ex_mem_pc+4 (modulo 2^DATA_WIDTH).
REQ-023 On any resolve event o_bp_update_en SHALL be 1 for exactly that cycle.
REQ-024 FSM states SHALL be RUN and RECOVER; RUN->RECOVER on mispredict; RECOVER->RUN after FLUSH_CYCLES cycles.
REQ-025 In RECOVER: window counter increments only when i_stall==0; o_flush=1; o_pc_sel=00; o_bp_update_en=0; branch opcodes at EX/MEM ignored (wrong-path).
REQ-026 In RUN without mispredict: o_pc_sel=01 if if_prediction==1, else 00; o_flush=0.
REQ-027 With i_stall==1 in RUN, resolution SHALL be deferred until the first cycle i_stall==0; no outputs other than o_pc_sel (REQ-026) change.
REQ-028 o_branch_cnt SHALL increment on each resolve event; o_mispredict_cnt on each mispredict; both saturate at all-ones, no wrap.
REQ-029 Correct predictions SHALL cause no flush and no state change.

Reset
REQ-030 While i_rst_n==0, asynchronously: state=RUN, window counter=0, both counters=0.
REQ-031 Reset mid-RECOVER SHALL abort recovery; first cycle after release is RUN with o_flush=0, o_bp_update_en=0.

Structure
REQ-032 A shared package SHALL hold B_TYPE opcode constant, pc_sel encodings, and the FSM state enum.
REQ-033 One sub-module sat_counter (parameter WIDTH, inputs inc, clk, rst_n; output count) SHALL be instantiated twice.

Verification
REQ-034 Correct taken: ex_mem B_TYPE, taken=1, pred=1 -> o_flush=0, o_bp_update_en=1 one cycle, o_branch_cnt=1, o_mispredict_cnt=0.
REQ-035 Mispredict not-taken: pc=0x100, taken=0, pred=1 -> o_pc_sel=11, o_pc_redirect=0x104, o_flush high 3 cycles (1+FLUSH_CYCLES), o_busy 2 cycles.
REQ-036 Mispredict taken, target=0x40, then B_TYPE during RECOVER -> redirect 0x40 once; second branch not counted, no update.
REQ-037 Stall: mispredict presented with i_stall=1 for 3 cycles -> no flush until stall drops; recovery window extended while stall reasserted inside RECOVER.
REQ-038 Saturation: CNT_WIDTH=4, 20 resolve events -> o_branch_cnt=4'hF.
REQ-039 Reset asserted in second RECOVER cycle -> o_busy=0 and counters=0 immediately, without waiting for a clock edge.
